// File: rtl/axi_dma_controller_pkg.sv
// Shared types and constants for the DMA command path.
//   burst_e        : AXI burst type encoding (FIXED/INCR/WRAP)
//   split_state_e  : burst splitter FSM states
//   burst_req_t    : one burst request as consumed by the AR/AW generators
//   size_mask()    : low-address mask for a given log2 beat size
package axi_dma_controller_pkg;

    localparam int BOUNDARY_4K   = 4096;
    localparam int AXI_MAX_LEN   = 256;
    localparam int FIXED_MAX_LEN = 16;   // AXI limit on FIXED burst length
    localparam int PKG_ADDR_WD   = 32;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } split_state_e;

    typedef struct packed {
        logic [PKG_ADDR_WD-1:0] src;
        logic [PKG_ADDR_WD-1:0] dst;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
        logic                   last;
    } burst_req_t;

    // Mask of the address/length bits that must be zero for a given beat size.
    function automatic logic [7:0] size_mask(input logic [2:0] size);
        return (8'd1 << size) - 8'd1;
    endfunction

endpackage

// File: rtl/axi_dma_beat_calc.sv
// Combinational beat count for the next burst of a command.
// Ports:
//   src, dst   : current source/destination byte addresses
//   rem_beats  : beats still to issue for the command
//   size       : log2 bytes per beat
//   burst      : burst type (FIXED ignores the 4 KB rule, capped at 16 beats)
//   beats      : beats in this burst (1..256)
//   last       : this burst finishes the command
module axi_dma_beat_calc
    import axi_dma_controller_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [ADDR_WD-1:0] src,
    input  logic [ADDR_WD-1:0] dst,
    input  logic [ADDR_WD-1:0] rem_beats,
    input  logic [2:0]         size,
    input  logic [1:0]         burst,
    output logic [8:0]         beats,
    output logic               last
);

    localparam int FIXED_CAP = (MAX_BURST_LEN < FIXED_MAX_LEN) ? MAX_BURST_LEN : FIXED_MAX_LEN;

    logic [ADDR_WD-1:0] addr_arr [2];
    logic [ADDR_WD-1:0] room     [2];
    logic [ADDR_WD-1:0] cap;
    logic [ADDR_WD-1:0] lim;

    assign addr_arr[0] = src;
    assign addr_arr[1] = dst;

    // Beats that fit before the next 4 KB boundary, one per side.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_room
            logic [ADDR_WD-1:0] offs;
            assign offs     = addr_arr[gi] & ADDR_WD'(BOUNDARY_4K - 1);
            assign room[gi] = (ADDR_WD'(BOUNDARY_4K) - offs) >> size;
        end
    endgenerate

    always_comb begin
        cap = (burst == FIXED) ? ADDR_WD'(FIXED_CAP) : ADDR_WD'(MAX_BURST_LEN);
        lim = (rem_beats < cap) ? rem_beats : cap;
        if (burst != FIXED) begin
            if (room[0] < lim) lim = room[0];
            if (room[1] < lim) lim = room[1];
        end
        beats = lim[8:0];
        last  = (lim == rem_beats);
    end

endmodule

// File: rtl/axi_dma_burst_splitter.sv
// DMA command front-end: validates a copy command and splits it into AXI
// burst requests that never cross a 4 KB boundary on either side and never
// exceed MAX_BURST_LEN beats.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cmd_*               : command handshake (src/dst address, burst, byte len, size)
//   cmd_err             : one-cycle pulse when a command is rejected
//   bst_*               : burst request handshake (len in AXI beats-1 encoding)
//   stat_cmds/bsts/errs : saturating counters, only with AXI_DMA_SPLIT_STATS_EN defined
module axi_dma_burst_splitter
    import axi_dma_controller_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_WD-1:0] cmd_src_addr,
    input  logic [ADDR_WD-1:0] cmd_dst_addr,
    input  logic [1:0]         cmd_burst,
    input  logic [ADDR_WD-1:0] cmd_len,
    input  logic [2:0]         cmd_size,
    output logic               cmd_err,
    output logic               bst_valid,
    input  logic               bst_ready,
    output logic [ADDR_WD-1:0] bst_src_addr,
    output logic [ADDR_WD-1:0] bst_dst_addr,
    output logic [7:0]         bst_len,
    output logic [2:0]         bst_size,
    output logic [1:0]         bst_burst,
    output logic               bst_last
`ifdef AXI_DMA_SPLIT_STATS_EN
    ,
    output logic [31:0]        stat_cmds,
    output logic [31:0]        stat_bsts,
    output logic [31:0]        stat_errs
`endif
);

    localparam int MAX_SIZE = $clog2(DATA_WD / 8);

    split_state_e       state_reg, state_next;
    logic [ADDR_WD-1:0] src_reg, src_next;
    logic [ADDR_WD-1:0] dst_reg, dst_next;
    logic [ADDR_WD-1:0] rem_reg, rem_next;
    logic [2:0]         size_reg, size_next;
    logic [1:0]         burst_reg, burst_next;
    logic               ready_reg, ready_next;
    logic               err_reg, err_next;

    logic [ADDR_WD-1:0] align_mask;
    logic               cmd_illegal;
    logic               cmd_accept;
    logic               bst_fire;
    logic [8:0]         beats;
    logic               calc_last;
    logic [ADDR_WD-1:0] step;

    axi_dma_beat_calc #(
        .ADDR_WD       (ADDR_WD),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_beat_calc (
        .src       (src_reg),
        .dst       (dst_reg),
        .rem_beats (rem_reg),
        .size      (size_reg),
        .burst     (burst_reg),
        .beats     (beats),
        .last      (calc_last)
    );

    assign align_mask  = ADDR_WD'(size_mask(cmd_size));
    assign cmd_illegal = (cmd_len == '0)
                      || (int'(cmd_size) > MAX_SIZE)
                      || (|(cmd_len      & align_mask))
                      || (|(cmd_src_addr & align_mask))
                      || (|(cmd_dst_addr & align_mask))
                      || ((cmd_burst != FIXED) && (cmd_burst != INCR));

    // ready_reg is only ever set while the FSM sits in IDLE, so it doubles
    // as the IDLE qualifier for a command handshake.
    assign cmd_accept = cmd_valid && ready_reg;
    assign bst_fire   = (state_reg == SPLIT) && bst_ready;
    assign step       = ADDR_WD'(beats) << size_reg;

    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        rem_next   = rem_reg;
        size_next  = size_reg;
        burst_next = burst_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_accept) begin
                    if (cmd_illegal) begin
                        err_next = 1'b1;
                    end else begin
                        src_next   = cmd_src_addr;
                        dst_next   = cmd_dst_addr;
                        size_next  = cmd_size;
                        burst_next = cmd_burst;
                        rem_next   = cmd_len >> cmd_size;
                        state_next = SPLIT;
                    end
                end
            end
            SPLIT: begin
                if (bst_fire) begin
                    rem_next = rem_reg - ADDR_WD'(beats);
                    if (burst_reg == INCR) begin
                        src_next = src_reg + step;
                        dst_next = dst_reg + step;
                    end
                    if (calc_last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            rem_reg   <= '0;
            size_reg  <= '0;
            burst_reg <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            rem_reg   <= rem_next;
            size_reg  <= size_next;
            burst_reg <= burst_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
        end
    end

    assign cmd_ready    = ready_reg;
    assign cmd_err      = err_reg;
    assign bst_valid    = (state_reg == SPLIT);
    assign bst_src_addr = src_reg;
    assign bst_dst_addr = dst_reg;
    assign bst_size     = size_reg;
    assign bst_burst    = burst_reg;
    // beats is 0 outside SPLIT; gate so the idle outputs read as zero.
    assign bst_len      = bst_valid ? 8'(beats - 9'd1) : 8'd0;
    assign bst_last     = bst_valid && calc_last;

`ifdef AXI_DMA_SPLIT_STATS_EN
    logic [31:0] cmds_reg, bsts_reg, errs_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmds_reg <= '0;
            bsts_reg <= '0;
            errs_reg <= '0;
        end else begin
            if (cmd_accept && !cmd_illegal && (cmds_reg != '1)) cmds_reg <= cmds_reg + 32'd1;
            if (bst_fire && (bsts_reg != '1))                   bsts_reg <= bsts_reg + 32'd1;
            if (err_reg && (errs_reg != '1))                    errs_reg <= errs_reg + 32'd1;
        end
    end

    assign stat_cmds = cmds_reg;
    assign stat_bsts = bsts_reg;
    assign stat_errs = errs_reg;
`endif

endmodule

// File: tb/tb_axi_dma_burst_splitter.sv
// Directed bench for axi_dma_burst_splitter (DATA_WD=32, MAX_BURST_LEN=16).
module tb_axi_dma_burst_splitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_src_addr = '0;
    logic [31:0] cmd_dst_addr = '0;
    logic [1:0]  cmd_burst = '0;
    logic [31:0] cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic        cmd_err;
    logic        bst_valid;
    logic        bst_ready = 1'b0;
    logic [31:0] bst_src_addr;
    logic [31:0] bst_dst_addr;
    logic [7:0]  bst_len;
    logic [2:0]  bst_size;
    logic [1:0]  bst_burst;
    logic        bst_last;
`ifdef AXI_DMA_SPLIT_STATS_EN
    logic [31:0] stat_cmds, stat_bsts, stat_errs;
`endif

    always #5 clk = ~clk;

    axi_dma_burst_splitter #(
        .ADDR_WD       (32),
        .DATA_WD       (32),
        .MAX_BURST_LEN (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_src_addr (cmd_src_addr),
        .cmd_dst_addr (cmd_dst_addr),
        .cmd_burst    (cmd_burst),
        .cmd_len      (cmd_len),
        .cmd_size     (cmd_size),
        .cmd_err      (cmd_err),
        .bst_valid    (bst_valid),
        .bst_ready    (bst_ready),
        .bst_src_addr (bst_src_addr),
        .bst_dst_addr (bst_dst_addr),
        .bst_len      (bst_len),
        .bst_size     (bst_size),
        .bst_burst    (bst_burst),
        .bst_last     (bst_last)
`ifdef AXI_DMA_SPLIT_STATS_EN
        ,
        .stat_cmds    (stat_cmds),
        .stat_bsts    (stat_bsts),
        .stat_errs    (stat_errs)
`endif
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          first;   // index of first expected burst
        int          nb;      // expected burst count, 0 = illegal command
    } cmd_vec_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        logic        last;
    } bst_exp_t;

    cmd_vec_t cmds[$];
    bst_exp_t exps[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nb);
        cmd_vec_t c;
        c.src = src; c.dst = dst; c.len = len; c.size = size; c.burst = burst;
        c.first = exps.size(); c.nb = nb;
        cmds.push_back(c);
    endtask

    task automatic add_exp(input logic [31:0] src, input logic [31:0] dst,
                           input logic [7:0] len, input logic last);
        bst_exp_t e;
        e.src = src; e.dst = dst; e.len = len; e.last = last;
        exps.push_back(e);
    endtask

    // Present a command and complete its handshake; returns #1 after the accepting edge.
    task automatic send_cmd(input cmd_vec_t c);
        int n;
        cmd_src_addr = c.src;
        cmd_dst_addr = c.dst;
        cmd_len      = c.len;
        cmd_size     = c.size;
        cmd_burst    = c.burst;
        cmd_valid    = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Drain the bursts of a legal command with bst_ready held high.
    task automatic expect_bursts(input cmd_vec_t c);
        int n;
        bst_ready = 1'b1;
        for (int k = 0; k < c.nb; k++) begin
            bst_exp_t e;
            e = exps[c.first + k];
            n = 0;
            while (!bst_valid && n < 20) begin
                tick();
                n++;
            end
            check("bst_valid", {31'd0, bst_valid}, 32'd1);
            check("bst_src", bst_src_addr, e.src);
            check("bst_dst", bst_dst_addr, e.dst);
            check("bst_len", {24'd0, bst_len}, {24'd0, e.len});
            check("bst_last", {31'd0, bst_last}, {31'd0, e.last});
            check("bst_size", {29'd0, bst_size}, {29'd0, c.size});
            check("bst_burst", {30'd0, bst_burst}, {30'd0, c.burst});
            if (e.last) check("cmd_ready_at_last", {31'd0, cmd_ready}, 32'd0);
            $display("burst src=%08h dst=%08h len=%0d last=%0b", bst_src_addr, bst_dst_addr, bst_len, bst_last);
            tick();
        end
        bst_ready = 1'b0;
        check("bst_valid_after_cmd", {31'd0, bst_valid}, 32'd0);
        check("cmd_ready_after_cmd", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic run_cmd(input cmd_vec_t c);
        send_cmd(c);
        $display("cmd src=%08h dst=%08h len=%0d size=%0d burst=%0d", c.src, c.dst, c.len, c.size, c.burst);
        if (c.nb == 0) begin
            check("err_pulse", {31'd0, cmd_err}, 32'd1);
            check("err_no_bst", {31'd0, bst_valid}, 32'd0);
            tick();
            check("err_single", {31'd0, cmd_err}, 32'd0);
            check("err_no_bst2", {31'd0, bst_valid}, 32'd0);
            check("err_ready", {31'd0, cmd_ready}, 32'd1);
        end else begin
            check("first_bst_latency", {31'd0, bst_valid}, 32'd1);
            check("no_err_legal", {31'd0, cmd_err}, 32'd0);
            expect_bursts(c);
        end
    endtask

    initial begin
        int  n;
        logic seen_last;

        // 0: single burst
        add_cmd(32'h1000, 32'h2000, 64, 2, 2'd1, 1);
        add_exp(32'h1000, 32'h2000, 8'd15, 1'b1);
        // 1: 50 beats -> 16,16,16,2
        add_cmd(32'h1000, 32'h2000, 200, 2, 2'd1, 4);
        add_exp(32'h1000, 32'h2000, 8'd15, 1'b0);
        add_exp(32'h1040, 32'h2040, 8'd15, 1'b0);
        add_exp(32'h1080, 32'h2080, 8'd15, 1'b0);
        add_exp(32'h10C0, 32'h20C0, 8'd1, 1'b1);
        // 4 KB crossing on src
        add_cmd(32'h0FF8, 32'h2000, 32, 2, 2'd1, 2);
        add_exp(32'h0FF8, 32'h2000, 8'd1, 1'b0);
        add_exp(32'h1000, 32'h2008, 8'd5, 1'b1);
        // 4 KB crossing on dst
        add_cmd(32'h3000, 32'h1FF0, 32, 2, 2'd1, 2);
        add_exp(32'h3000, 32'h1FF0, 8'd3, 1'b0);
        add_exp(32'h3010, 32'h2000, 8'd3, 1'b1);
        // illegal commands interleaved with legal ones
        add_cmd(32'h1000, 32'h2000, 6, 2, 2'd1, 0);
        add_cmd(32'h1000, 32'h2000, 0, 2, 2'd1, 0);
        add_cmd(32'h1000, 32'h2000, 64, 2, 2'd2, 0);
        add_cmd(32'h1002, 32'h2000, 64, 2, 2'd1, 0);
        add_cmd(32'h1000, 32'h2000, 64, 3, 2'd1, 0);
        add_cmd(32'h1000, 32'h2000, 64, 2, 2'd3, 0);
        add_cmd(32'h1000, 32'h2001, 64, 1, 2'd1, 0);
        // FIXED: addresses held, capped at 16 beats
        add_cmd(32'h0100, 32'h0200, 128, 2, 2'd0, 2);
        add_exp(32'h0100, 32'h0200, 8'd15, 1'b0);
        add_exp(32'h0100, 32'h0200, 8'd15, 1'b1);
        // FIXED ignores the 4 KB room
        add_cmd(32'h0FFC, 32'h2000, 8, 2, 2'd0, 1);
        add_exp(32'h0FFC, 32'h2000, 8'd1, 1'b1);
        // byte-sized beats
        add_cmd(32'h0010, 32'h0020, 5, 0, 2'd1, 1);
        add_exp(32'h0010, 32'h0020, 8'd4, 1'b1);
        // address wrap at 2^32
        add_cmd(32'hFFFF_FFF0, 32'h0000_0000, 64, 2, 2'd1, 2);
        add_exp(32'hFFFF_FFF0, 32'h0000_0000, 8'd3, 1'b0);
        add_exp(32'h0000_0000, 32'h0000_0010, 8'd11, 1'b1);

        // reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_bst_valid", {31'd0, bst_valid}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("rst_bst_len", {24'd0, bst_len}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < cmds.size(); i++) run_cmd(cmds[i]);

        // backpressure on the 2nd burst of the 200-byte command
        send_cmd(cmds[1]);
        bst_ready = 1'b1;
        check("bp_b0_src", bst_src_addr, 32'h1000);
        tick();
        bst_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("bp_valid", {31'd0, bst_valid}, 32'd1);
            check("bp_src", bst_src_addr, 32'h1040);
            check("bp_dst", bst_dst_addr, 32'h2040);
            check("bp_len", {24'd0, bst_len}, 32'd15);
            check("bp_last", {31'd0, bst_last}, 32'd0);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            $display("stall cycle %0d src=%08h len=%0d", j, bst_src_addr, bst_len);
            tick();
        end
        bst_ready = 1'b1;
        n = 1;
        for (int j = 0; j < 20; j++) begin
            if (bst_valid) begin
                n++;
                seen_last = bst_last;
                tick();
                if (seen_last) break;
            end else begin
                tick();
            end
        end
        bst_ready = 1'b0;
        check("bp_burst_count", n, 4);
        check("bp_idle_after", {31'd0, bst_valid}, 32'd0);

        // reset in the middle of a split
        send_cmd(cmds[1]);
        bst_ready = 1'b1;
        check("mid_rst_b0_src", bst_src_addr, 32'h1000);
        tick();
        bst_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_bst_valid", {31'd0, bst_valid}, 32'd0);
        check("mid_rst_bst_last", {31'd0, bst_last}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_valid_after", {31'd0, bst_valid}, 32'd0);
        $display("reset mid-split done");
        run_cmd(cmds[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
